// File: rtl/clk_sched_pkg.sv
// Shared types and defaults for the slow-clock scheduler: FSM state encoding
// and default widths/limits used as parameter defaults by the top.
package clk_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        ACK       = 2'd2
    } state_t;

    localparam int DW_DEF      = 32;
    localparam int MIN_DIV_DEF = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// ptr_i (wrapping) and returns it as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    logic [PW-1:0] sel;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sel     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel = PW'((int'(ptr_i) + k) % NREQ);
            if (!valid_o && req_i[sel]) begin
                valid_o      = 1'b1;
                grant_o[sel] = 1'b1;
                idx_o        = sel;
            end
        end
    end

endmodule

// File: rtl/slow_clk_scheduler.sv
// Toggle-style slow-clock divider whose ratio is shared between NREQ requesters;
// ratio changes are applied only on a toggle. Optional SLOW_CLK_FREEZE_EN adds 'freeze'.
module slow_clk_scheduler
    import clk_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DW          = DW_DEF,
    parameter int DEFAULT_DIV = 49_999_999,
    parameter int MIN_DIV     = MIN_DIV_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SLOW_CLK_FREEZE_EN
    input  logic               freeze,
`endif
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] div_val,
    output logic [NREQ-1:0]    ack,
    output logic               slow_clk,
    output logic               tick,
    output logic [DW-1:0]      active_div,
    output logic               busy
);

    localparam int PW = $clog2(NREQ);

    function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] v);
        return (v < DW'(MIN_DIV)) ? DW'(MIN_DIV) : v;
    endfunction

    state_t          state_q, state_d;
    logic [DW-1:0]   count_q, count_d;
    logic            slow_clk_q, slow_clk_d;
    logic            tick_q, tick_d;
    logic [DW-1:0]   active_div_q, active_div_d;
    logic [DW-1:0]   pend_q, pend_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] ack_q, ack_d;

    logic [NREQ-1:0] arb_grant;
    logic [PW-1:0]   arb_idx;
    logic            arb_valid;
    logic [DW-1:0]   sel_div;
    logic [DW-1:0]   sel_clamped;
    logic            run;
    logic            hit;

`ifdef SLOW_CLK_FREEZE_EN
    assign run = ~freeze;
`else
    assign run = 1'b1;
`endif

    assign hit = run && (count_q == active_div_q);

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        sel_div = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) sel_div = div_val[i*DW +: DW];
        end
        sel_clamped = clamp_div(sel_div);
    end

    always_comb begin
        count_d      = count_q;
        slow_clk_d   = slow_clk_q;
        tick_d       = 1'b0;
        active_div_d = active_div_q;
        state_d      = state_q;
        pend_d       = pend_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        busy_d       = busy_q;
        ack_d        = '0;

        if (hit) begin
            count_d    = '0;
            slow_clk_d = ~slow_clk_q;
            tick_d     = 1'b1;
        end else if (run) begin
            count_d = count_q + DW'(1);
        end

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    pend_d   = sel_clamped;
                    grant_d  = arb_grant;
                    rr_ptr_d = PW'((int'(arb_idx) + 1) % NREQ);
                    busy_d   = 1'b1;
                    // A ratio equal to the active one needs no toggle boundary.
                    state_d  = (sel_clamped == active_div_q) ? ACK : WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (hit) begin
                    active_div_d = pend_q;
                    state_d      = ACK;
                end
            end
            ACK: begin
                ack_d   = grant_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            slow_clk_q   <= 1'b0;
            tick_q       <= 1'b0;
            active_div_q <= DW'(DEFAULT_DIV);
            pend_q       <= '0;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            busy_q       <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            slow_clk_q   <= slow_clk_d;
            tick_q       <= tick_d;
            active_div_q <= active_div_d;
            pend_q       <= pend_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
        end
    end

    assign ack        = ack_q;
    assign slow_clk   = slow_clk_q;
    assign tick       = tick_q;
    assign active_div = active_div_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_slow_clk_scheduler.sv
// Directed bench for slow_clk_scheduler (NREQ=4, DEFAULT_DIV=3, MIN_DIV=1) with
// an acknowledge scoreboard: expected grant/ratio/latency queued when a request is driven.
module tb_slow_clk_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] div_val;
    logic [NREQ-1:0]    ack;
    logic               slow_clk;
    logic               tick;
    logic [DW-1:0]      active_div;
    logic               busy;
`ifdef SLOW_CLK_FREEZE_EN
    logic               freeze;
    initial freeze = 1'b0;
`endif

    slow_clk_scheduler #(
        .NREQ        (NREQ),
        .DW          (DW),
        .DEFAULT_DIV (3),
        .MIN_DIV     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SLOW_CLK_FREEZE_EN
        .freeze     (freeze),
`endif
        .req        (req),
        .div_val    (div_val),
        .ack        (ack),
        .slow_clk   (slow_clk),
        .tick       (tick),
        .active_div (active_div),
        .busy       (busy)
    );

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [DW-1:0]   div;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the cycle where tick is seen; the divider count is then 0.
    task automatic align();
        int n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 40);
        check("align_tick", {63'd0, tick}, 64'd1);
    endtask

    task automatic measure_half(input string tag, input int exp_n);
        int n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 40);
        check(tag, n, exp_n);
    endtask

    task automatic wait_ack(input string tag);
        int   n = 0;
        exp_t e;
        do begin
            step();
            n++;
        end while (ack === '0 && n < 40);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_ack"}, ack, e.ack);
            check({tag, "_div"}, active_div, e.div);
            check({tag, "_lat"}, n, e.lat);
            check({tag, "_busy"}, busy, 0);
        end
    endtask

    task automatic do_req(input string tag, input int idx, input logic [DW-1:0] dv,
                          input logic [DW-1:0] exp_div, input int total_lat);
        exp_t e;
        align();
        req[idx] = 1'b1;
        div_val[idx*DW +: DW] = dv;
        e.ack = NREQ'(1) << idx;
        e.div = exp_div;
        e.lat = total_lat - 1;
        sb.push_back(e);
        step();
        req = '0;
        check({tag, "_busy_set"}, busy, 1);
        wait_ack(tag);
    endtask

    initial begin
        exp_t e;
        rst_n   = 1'b0;
        req     = '0;
        div_val = '0;

        // 1: reset values, then free-running divide by 4
        repeat (3) @(posedge clk);
        #1;
        check("rst_slow", slow_clk, 0);
        check("rst_tick", tick, 0);
        check("rst_div", active_div, 3);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("t1_slow_%0d", k), slow_clk, (k / 4) % 2);
            check($sformatf("t1_tick_%0d", k), tick, (k % 4) == 0);
            check($sformatf("t1_ack_%0d", k), ack, 0);
        end

        // 2: req[1] div=1 issued at count=0; ratio applies only at the next toggle
        align();
        req[1] = 1'b1;
        div_val[1*DW +: DW] = 32'd1;
        e.ack = 4'b0010; e.div = 1; e.lat = 1;
        sb.push_back(e);
        step();
        req = '0;
        check("t2_busy", busy, 1);
        check("t2_div_c1", active_div, 3);
        step();
        check("t2_div_c2", active_div, 3);
        step();
        check("t2_div_c3", active_div, 3);
        check("t2_noack", ack, 0);
        step();
        check("t2_tick", tick, 1);
        check("t2_div_apply", active_div, 1);
        check("t2_ack_early", ack, 0);
        wait_ack("t2");
        align();
        measure_half("t2_half", 2);
        measure_half("t2_half_b", 2);

        // reset to bring rr_ptr back to 0
        rst_n = 1'b0;
        #1;
        check("rst2_div", active_div, 3);
        check("rst2_slow", slow_clk, 0);
        step();
        step();
        rst_n = 1'b1;

        // 3: req[0] and req[2] together; the second capture lands on a toggle cycle
        align();
        req = 4'b0101;
        div_val[0*DW +: DW] = 32'd1;
        div_val[2*DW +: DW] = 32'd2;
        e.ack = 4'b0001; e.div = 1; e.lat = 4;
        sb.push_back(e);
        e.ack = 4'b0100; e.div = 2; e.lat = 3;
        sb.push_back(e);
        step();
        req[0] = 1'b0;
        check("t3_busy", busy, 1);
        wait_ack("t3a");
        step();
        req[2] = 1'b0;
        check("t3_busy_b", busy, 1);
        wait_ack("t3b");

        // 4: rr_ptr is 3, so req[3] beats req[1]; div 0 clamps to 1
        align();
        req = 4'b1010;
        div_val[3*DW +: DW] = 32'd0;
        div_val[1*DW +: DW] = 32'd5;
        e.ack = 4'b1000; e.div = 1; e.lat = 3;
        sb.push_back(e);
        step();
        req = '0;
        check("t4_busy", busy, 1);
        wait_ack("t4");

        do_req("t45", 1, 32'd3, 32'd3, 3);

        // 5: equal ratio acknowledges without waiting for a toggle
        do_req("t5", 2, 32'd3, 32'd3, 2);
        align();
        measure_half("t5_half", 4);

        do_req("t56", 0, 32'd2, 32'd2, 5);

        // 6: reset while waiting for the edge drops the request
        align();
        req[3] = 1'b1;
        div_val[3*DW +: DW] = 32'd1;
        step();
        req = '0;
        step();
        check("t6_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_slow", slow_clk, 0);
        check("t6_rst_tick", tick, 0);
        check("t6_rst_div", active_div, 3);
        check("t6_rst_ack", ack, 0);
        check("t6_rst_busy", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t6_ack_%0d", k), ack, 0);
            check($sformatf("t6_tick_%0d", k), tick, (k % 4) == 0);
            check($sformatf("t6_div_%0d", k), active_div, 3);
        end

        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
